// File: rtl/rng_ctrl_pkg.sv
// Shared definitions for the RNG-driven matrix fill controller: state encoding,
// counter widths and the dimension legality helper.
package rng_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int DIM_W  = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_t;

    function automatic logic dim_legal(input logic [DIM_W-1:0] d, input int max_dim);
        return (d != '0) && (int'(d) <= max_dim);
    endfunction

endpackage

// File: rtl/rng_matrix_filler.sv
// Steps an external RNG once per element and writes each result into an m x n
// matrix store in row-major order, pulsing done after the last write.
module rng_matrix_filler
    import rng_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_DIM = 5,
    parameter int RNG_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [WIDTH-1:0]  val_min,
    input  logic [WIDTH-1:0]  val_max,
    output logic              rng_en,
    output logic [WIDTH-1:0]  rng_min,
    output logic [WIDTH-1:0]  rng_max,
    input  logic [WIDTH-1:0]  rng_num,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DIM_W-1:0]  wr_row,
    output logic [DIM_W-1:0]  wr_col,
    output logic [WIDTH-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WAIT_W = (RNG_LAT > 1) ? $clog2(RNG_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RNG_LAT - 1);

    state_t            state_reg;
    logic [DIM_W-1:0]  m_reg;
    logic [DIM_W-1:0]  n_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              params_ok;
    logic              last_elem;

    assign params_ok = dim_legal(dim_m, MAX_DIM) && dim_legal(dim_n, MAX_DIM)
                       && (val_min <= val_max);
    assign last_elem = (wr_row == m_reg - DIM_W'(1)) && (wr_col == n_reg - DIM_W'(1));

    // The RNG result is only meaningful while writing, so it is passed straight through.
    assign wr_data = (state_reg == WRITE) ? rng_num : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            m_reg        <= '0;
            n_reg        <= '0;
            wait_cnt_reg <= '0;
            rng_en       <= 1'b0;
            rng_min      <= '0;
            rng_max      <= '1;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_row       <= '0;
            wr_col       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            rng_en <= 1'b0;
            wr_en  <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            if (state_reg != IDLE && abort) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start && !abort) begin
                            if (params_ok) begin
                                m_reg     <= dim_m;
                                n_reg     <= dim_n;
                                rng_min   <= val_min;
                                rng_max   <= val_max;
                                wr_addr   <= '0;
                                wr_row    <= '0;
                                wr_col    <= '0;
                                rng_en    <= 1'b1;
                                busy      <= 1'b1;
                                state_reg <= REQ;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    REQ: begin
                        wait_cnt_reg <= '0;
                        state_reg    <= WAIT;
                    end
                    WAIT: begin
                        if (wait_cnt_reg == WAIT_LAST) begin
                            wr_en     <= 1'b1;
                            state_reg <= WRITE;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                        end
                    end
                    WRITE: begin
                        if (last_elem) begin
                            done      <= 1'b1;
                            state_reg <= FIN;
                        end else begin
                            // Counters move to the next element only after its write cycle.
                            wr_addr <= wr_addr + ADDR_W'(1);
                            if (wr_col == n_reg - DIM_W'(1)) begin
                                wr_col <= '0;
                                wr_row <= wr_row + DIM_W'(1);
                            end else begin
                                wr_col <= wr_col + DIM_W'(1);
                            end
                            rng_en    <= 1'b1;
                            state_reg <= REQ;
                        end
                    end
                    FIN: begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                    default: begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
